// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests and fills the IF/ID register.
// A two-state RUN/HALT controller; only rst leaves HALT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_dec,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_inc,
  output logic [4:0]  opcode,
  output logic [1:0]  op_ext,
  output logic        halted
);

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(2);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_inc_q, pc_inc_d;
  logic [XLEN-1:0] pc_plus2;

  // Wraps modulo 2^16 by width truncation.
  assign pc_plus2 = pc_q + PC_STEP;

  // Next-state and fetch request; priority is redirect, halt, stall, fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_inc_d = pc_inc_q;
    imem_req = 1'b0;
    if (state_q == RUN) begin
      imem_req = !stall && !redirect_valid;
      if (redirect_valid) begin
        pc_d    = {redirect_pc[XLEN-1:1], 1'b0};
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end else if (halt_dec && valid_q) begin
        state_d = HALT;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (imem_ack) begin
        pc_d     = pc_plus2;
        pc_inc_d = pc_plus2;
        valid_d  = 1'b1;
        instr_d  = imem_data;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  // State and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_inc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_inc_q <= pc_inc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_valid  = valid_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc_inc = pc_inc_q;
  assign opcode       = instr_q[15:11];
  assign op_ext       = instr_q[1:0];
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random traffic, checked
// against a rule-level reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_dec;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic [4:0]  opcode;
  logic [1:0]  op_ext;
  logic        halted;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_dec(halt_dec),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc_inc(if_id_pc_inc),
    .opcode(opcode), .op_ext(op_ext), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Reference model: architectural view of the fetch stage.
  int          m_pc;
  bit          m_halted;
  bit          m_valid;
  logic [15:0] m_instr;
  int          m_pc_inc;

  task automatic model_reset();
    m_pc     = int'(RESET_PC);
    m_halted = 1'b0;
    m_valid  = 1'b0;
    m_instr  = NOP_INSTR;
    m_pc_inc = 0;
  endtask

  task automatic model_cycle(input logic r, input logic s, input logic rv,
                             input logic [15:0] rp, input logic hd,
                             input logic ack, input logic [15:0] d);
    if (r) begin
      model_reset();
    end else if (m_halted) begin
      // everything ignored until reset
    end else if (rv) begin
      m_pc    = int'(rp) - (int'(rp) % 2);
      m_valid = 1'b0;
      m_instr = NOP_INSTR;
    end else if (hd && m_valid) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
      m_instr  = NOP_INSTR;
    end else if (s) begin
      // hold
    end else if (ack) begin
      m_pc     = (m_pc + 2) % 65536;
      m_pc_inc = m_pc;
      m_valid  = 1'b1;
      m_instr  = d;
    end else begin
      m_valid = 1'b0;
      m_instr = NOP_INSTR;
    end
  endtask

  // Drive one cycle of inputs, record what the DUT must show during it, then advance the model.
  task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rp,
                      input logic hd, input logic ack, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    halt_dec = hd; imem_ack = ack; imem_data = d;
    e.req    = !m_halted && !s && !rv;
    e.addr   = 16'(m_pc);
    e.valid  = m_valid;
    e.instr  = m_instr;
    e.pc_inc = 16'(m_pc_inc);
    e.halted = m_halted;
    exp_q.push_back(e);
    model_cycle(r, s, rv, rp, hd, ack, d);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: sample settled outputs mid low-phase and compare against the scoreboard.
  initial begin
    exp_t e;
    logic [15:0] tmp;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_req",    16'(imem_req),    16'(e.req));
        chk("imem_addr",   imem_addr,        e.addr);
        chk("if_id_valid", 16'(if_id_valid), 16'(e.valid));
        chk("if_id_instr", if_id_instr,      e.instr);
        tmp = e.instr;
        chk("opcode",      16'(opcode),      16'(tmp[15:11]));
        chk("op_ext",      16'(op_ext),      16'(tmp[1:0]));
        chk("halted",      16'(halted),      16'(e.halted));
        if (e.valid) chk("if_id_pc_inc", if_id_pc_inc, e.pc_inc);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_dec = 1'b0; imem_ack = 1'b0; imem_data = '0;
    model_reset();
    @(posedge clk);
    step(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
    // Back-to-back acks, then a 3-cycle stall holding A001.
    step(0, 0, 0, 16'h0000, 0, 1, 16'hA000);
    step(0, 0, 0, 16'h0000, 0, 1, 16'hA001);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0000, 0, 1, 16'hBEEF);
    step(0, 0, 0, 16'h0000, 0, 1, 16'hA002);
    step(0, 0, 0, 16'h0000, 0, 1, 16'hA003);
    // Redirect to odd target with a same-cycle ack that must be dropped.
    step(0, 0, 1, 16'h0101, 0, 1, 16'hC0DE);
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 1, 16'h1235);
    // PC wrap at the top of the address space.
    step(0, 0, 1, 16'hFFFE, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 1, 16'h5A5A);
    step(0, 0, 0, 16'h0000, 0, 1, 16'h6B6B);
    // Halt, then redirect/stall/ack are ignored until reset.
    step(0, 0, 0, 16'h0000, 1, 1, 16'h7777);
    step(0, 0, 1, 16'h4444, 0, 1, 16'h8888);
    step(0, 1, 0, 16'h0000, 0, 1, 16'h9999);
    step(0, 0, 0, 16'h0000, 1, 1, 16'hAAAA);
    step(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 1, 16'h2222);
    step(0, 0, 0, 16'h0000, 0, 1, 16'h3333);
    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic r, s, rv, hd, ack;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      rv  = ($urandom_range(0, 99) < 10);
      hd  = ($urandom_range(0, 99) < 4);
      ack = ($urandom_range(0, 99) < 70);
      step(r, s, rv, 16'($urandom), hd, ack, 16'($urandom));
    end
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
